// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator
// Description : Collects N_SAMPLES unsigned 5-bit sums from an upstream adder
//               into a saturating running total. Once a batch is complete the
//               total is held with out_valid until the consumer takes it.
//               A synchronous clear aborts the current batch.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
  parameter int ACC_WIDTH = 8,
  parameter int N_SAMPLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           s_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic [3:0]           cnt,
  output logic                 ovf,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [3:0] c_n_samples = 4'(N_SAMPLES);

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  // One extra bit on the adder so a carry out of the total flags saturation.
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_sat;
  logic                 w_accept;
  logic                 w_handshake;
  logic [3:0]           w_cnt_inc;

  assign w_sum       = {1'b0, acc_q} + (ACC_WIDTH+1)'(s_in);
  assign w_sat       = w_sum[ACC_WIDTH];
  assign w_accept    = in_valid && (state_q == ACCUM);
  assign w_handshake = out_valid_q && out_ready;
  assign w_cnt_inc   = cnt_q + 4'd1;

  // Next-state and datapath: clear beats handshake beats accept.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear || w_handshake) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = 4'd0;
      ovf_d   = 1'b0;
    end else if (w_accept) begin
      acc_d = w_sat ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
      ovf_d = ovf_q | w_sat;
      cnt_d = w_cnt_inc;
      if (w_cnt_inc == c_n_samples) begin
        state_d = DONE;
      end
    end
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= 4'd0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign acc_out   = acc_q;
  assign cnt       = cnt_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_accumulator
// Description : Bench for sum_accumulator. Three instances cover the default
//               build, ACC_WIDTH=6 and N_SAMPLES=1. A reference model keeps
//               the plain unsaturated batch total; completed batches go into a
//               per-instance queue that a monitor drains when out_valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] s_in      [3];
  logic       in_valid  [3];
  logic       clear     [3];
  logic       out_ready [3];
  logic       in_ready  [3];
  logic [3:0] cnt       [3];
  logic       ovf       [3];
  logic       out_valid [3];
  logic [7:0] acc0;
  logic [5:0] acc1;
  logic [7:0] acc2;

  sum_accumulator #(.ACC_WIDTH(8), .N_SAMPLES(4)) u_def (
    .clk(clk), .rst_n(rst_n), .s_in(s_in[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .clear(clear[0]), .acc_out(acc0), .cnt(cnt[0]),
    .ovf(ovf[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));

  sum_accumulator #(.ACC_WIDTH(6), .N_SAMPLES(4)) u_w6 (
    .clk(clk), .rst_n(rst_n), .s_in(s_in[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .clear(clear[1]), .acc_out(acc1), .cnt(cnt[1]),
    .ovf(ovf[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));

  sum_accumulator #(.ACC_WIDTH(8), .N_SAMPLES(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .s_in(s_in[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .clear(clear[2]), .acc_out(acc2), .cnt(cnt[2]),
    .ovf(ovf[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

  typedef struct {
    int unsigned acc;
    int unsigned cnt;
    bit          ovf;
  } res_t;

  int          total = 0;
  int          bad   = 0;
  int unsigned c_max [3] = '{255, 63, 255};
  int unsigned c_ns  [3] = '{4, 4, 1};

  // Model: the true (unsaturated) batch total and count, plus whether a
  // finished batch is waiting for the consumer.
  int unsigned m_tot  [3];
  int unsigned m_cnt  [3];
  bit          m_done [3];
  res_t        sb_q   [3][$];
  bit          prev_v [3] = '{1'b0, 1'b0, 1'b0};

  function automatic int unsigned acc_of(int d);
    case (d)
      0:       return int'(acc0);
      1:       return int'(acc1);
      default: return int'(acc2);
    endcase
  endfunction

  function automatic int unsigned sat(int d, int unsigned v);
    return (v > c_max[d]) ? c_max[d] : v;
  endfunction

  task automatic chk(string name, int d, int unsigned act, int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk("acc_out",   d, acc_of(d),         sat(d, m_tot[d]));
      chk("cnt",       d, int'(cnt[d]),      m_cnt[d]);
      chk("ovf",       d, int'(ovf[d]),      int'(m_tot[d] > c_max[d]));
      chk("out_valid", d, int'(out_valid[d]), int'(m_done[d]));
      chk("in_ready",  d, int'(in_ready[d]),  int'(!m_done[d]));
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_tot[d]  = 0;
      m_cnt[d]  = 0;
      m_done[d] = 1'b0;
      sb_q[d].delete();
    end
  endtask

  // Applies one rising edge worth of behaviour to the model.
  task automatic model_edge();
    res_t r;
    for (int d = 0; d < 3; d++) begin
      if (clear[d]) begin
        m_tot[d] = 0; m_cnt[d] = 0; m_done[d] = 1'b0;
      end else if (m_done[d]) begin
        if (out_ready[d]) begin
          m_tot[d] = 0; m_cnt[d] = 0; m_done[d] = 1'b0;
        end
      end else if (in_valid[d]) begin
        m_tot[d] += int'(s_in[d]);
        m_cnt[d] += 1;
        if (m_cnt[d] == c_ns[d]) begin
          m_done[d] = 1'b1;
          r.acc = sat(d, m_tot[d]);
          r.cnt = m_cnt[d];
          r.ovf = (m_tot[d] > c_max[d]);
          sb_q[d].push_back(r);
        end
      end
    end
  endtask

  task automatic drive(int d, bit v, int s, bit c, bit r);
    in_valid[d]  = v;
    s_in[d]      = 5'(s);
    clear[d]     = c;
    out_ready[d] = r;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Scoreboard monitor: each new completed batch must match the oldest
  // expected result for that instance.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (out_valid[d] === 1'b1 && !prev_v[d]) begin
        if (sb_q[d].size() == 0) begin
          total++;
          bad++;
          $display("FAIL batch_unexpected dut%0d: got out_valid=1 expected no batch", d);
        end else begin
          res_t r;
          r = sb_q[d].pop_front();
          chk("batch_acc", d, acc_of(d),     r.acc);
          chk("batch_cnt", d, int'(cnt[d]),  r.cnt);
          chk("batch_ovf", d, int'(ovf[d]),  int'(r.ovf));
        end
      end
      prev_v[d] = (out_valid[d] === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_all();
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Default build: 5+10+31+0 = 46 after the fourth accept.
    drive(0, 1, 5, 0, 0);  step();
    drive(0, 1, 10, 0, 0); step();
    drive(0, 1, 31, 0, 0); step();
    drive(0, 1, 0, 0, 0);  step();
    // Held in DONE while upstream keeps offering data.
    drive(0, 1, 7, 0, 0);
    repeat (3) step();
    drive(0, 0, 0, 0, 1);  step();
    drive(0, 0, 0, 0, 0);  step();

    // Six-bit total saturates at 63 from the third accept.
    drive(1, 1, 31, 0, 0); step();
    step();
    step();
    drive(1, 1, 2, 0, 0);  step();
    drive(1, 0, 0, 0, 1);  step();
    drive(1, 0, 0, 0, 0);  step();

    // Clear with a concurrent valid sum discards both the batch and the sum.
    drive(0, 1, 3, 0, 0);  step();
    drive(0, 1, 4, 0, 0);  step();
    drive(0, 1, 9, 1, 0);  step();
    drive(0, 1, 1, 0, 0);
    repeat (4) step();
    drive(0, 0, 0, 0, 1);  step();
    drive(0, 0, 0, 0, 0);  step();

    // Single-sample batches.
    drive(2, 1, 17, 0, 0); step();
    drive(2, 0, 0, 0, 1);  step();
    drive(2, 0, 0, 0, 0);  step();

    // Asynchronous reset pulse mid-batch, between clock edges.
    drive(0, 1, 20, 0, 0); step();
    step();
    idle_all();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    #1 rst_n = 1'b1;
    drive(0, 1, 8, 0, 0);  step();
    idle_all();            step();
    drive(0, 1, 0, 1, 0);  step();

    // Randomised traffic on all three instances.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 3; d++) begin
        drive(d, ($urandom % 4) != 0, int'($urandom % 32),
              ($urandom % 25) == 0, ($urandom % 2) == 1);
      end
      step();
    end

    idle_all();
    step();
    for (int d = 0; d < 3; d++) chk("sb_leftover", d, sb_q[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
